ecc_host_link: RTL and testbench

ECC_HOST_LINK -- requirements
Module: ecc_host_link

---
 rtl/ecc_host_link_pkg.sv | 21 ++
 rtl/ecc_host_link_if.sv | 37 +++
 rtl/ecc_host_link_deser.sv | 79 +++++++
 rtl/ecc_host_link.sv | 155 +++++++++++++++
 tb/tb_ecc_host_link.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_host_link_pkg.sv
// Shared definitions for the ECC host link: operand sizing, counter width, mode encodings.
package ECCDefine;

    localparam int unsigned MAX_BITS = 256;
    localparam int unsigned MAX_REG  = $clog2(MAX_BITS) + 1;

    localparam logic [1:0] BITS32  = 2'b00;
    localparam logic [1:0] BITS64  = 2'b01;
    localparam logic [1:0] BITS128 = 2'b10;
    localparam logic [1:0] BITS256 = 2'b11;

    function automatic logic [MAX_REG-1:0] mode_nbits(input logic [1:0] mode);
        case (mode)
            BITS32:  mode_nbits = MAX_REG'(32);
            BITS64:  mode_nbits = MAX_REG'(64);
            BITS128: mode_nbits = MAX_REG'(128);
            default: mode_nbits = MAX_REG'(256);
        endcase
    endfunction

endpackage

// File: rtl/ecc_host_link_if.sv
// Host-side operand/result bus and the serial lines to and from the ECC core.
interface ecc_host_link_if #(
    parameter int unsigned MAX_BITS = ECCDefine::MAX_BITS
) ();

    logic                i_start_pa;
    logic [1:0]          i_mode;
    logic [MAX_BITS-1:0] i_P, i_prime, i_ax, i_ay;
    logic                i_start_pb;
    logic [MAX_BITS-1:0] i_Pbx, i_Pby;
    logic                o_tx_ready;

    logic o_p_a_valid, o_mode, o_P, o_prime, o_ax, o_ay;
    logic o_pb_valid, o_Pbx, o_Pby;

    logic i_Pa_valid, i_Pax, i_Pay, i_Pab_valid, i_Pabx, i_Paby;

    logic [MAX_BITS-1:0] o_pax, o_pay, o_pabx, o_paby;
    logic                o_pa_done, o_pab_done;

    modport slave (
        input  i_start_pa, i_mode, i_P, i_prime, i_ax, i_ay, i_start_pb, i_Pbx, i_Pby,
        input  i_Pa_valid, i_Pax, i_Pay, i_Pab_valid, i_Pabx, i_Paby,
        output o_tx_ready, o_p_a_valid, o_mode, o_P, o_prime, o_ax, o_ay,
        output o_pb_valid, o_Pbx, o_Pby,
        output o_pax, o_pay, o_pabx, o_paby, o_pa_done, o_pab_done
    );

    modport master (
        output i_start_pa, i_mode, i_P, i_prime, i_ax, i_ay, i_start_pb, i_Pbx, i_Pby,
        output i_Pa_valid, i_Pax, i_Pay, i_Pab_valid, i_Pabx, i_Paby,
        input  o_tx_ready, o_p_a_valid, o_mode, o_P, o_prime, o_ax, o_ay,
        input  o_pb_valid, o_Pbx, o_Pby,
        input  o_pax, o_pay, o_pabx, o_paby, o_pa_done, o_pab_done
    );

endinterface

// File: rtl/ecc_host_link_deser.sv
// Deserializer for one x/y result pair: MSB-first frame framed by a single valid line.
module ecc_deser import ECCDefine::*; #(
    parameter int unsigned MAX_BITS = ECCDefine::MAX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic                data_x_i,
    input  logic                data_y_i,
    input  logic [MAX_REG-1:0]  nbits_i,
    output logic [MAX_BITS-1:0] result_x_o,
    output logic [MAX_BITS-1:0] result_y_o,
    output logic                done_o
);

    typedef enum logic [1:0] {StRxIdle, StRxShift, StRxHold} rx_state_e;

    rx_state_e           state_q, state_d;
    logic [MAX_REG-1:0]  cnt_q, cnt_d;
    logic [MAX_BITS-1:0] res_x_q, res_x_d, res_y_q, res_y_d;
    logic                done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_x_d = res_x_q;
        res_y_d = res_y_q;
        done_d  = 1'b0;
        case (state_q)
            StRxIdle: begin
                // First bit arrives with the rising valid; old result is discarded here.
                if (valid_i) begin
                    state_d = StRxShift;
                    cnt_d   = MAX_REG'(1);
                    res_x_d = {{(MAX_BITS-1){1'b0}}, data_x_i};
                    res_y_d = {{(MAX_BITS-1){1'b0}}, data_y_i};
                end
            end
            StRxShift: begin
                if (!valid_i) begin
                    state_d = StRxIdle;
                end else begin
                    res_x_d = {res_x_q[MAX_BITS-2:0], data_x_i};
                    res_y_d = {res_y_q[MAX_BITS-2:0], data_y_i};
                    cnt_d   = cnt_q + MAX_REG'(1);
                    if (cnt_d >= nbits_i) begin
                        done_d  = 1'b1;
                        state_d = StRxHold;
                    end
                end
            end
            StRxHold: begin
                if (!valid_i) state_d = StRxIdle;
            end
            default: state_d = StRxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRxIdle;
            cnt_q   <= '0;
            res_x_q <= '0;
            res_y_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_x_q <= res_x_d;
            res_y_q <= res_y_d;
            done_q  <= done_d;
        end
    end

    assign result_x_o = res_x_q;
    assign result_y_o = res_y_q;
    assign done_o     = done_q;

endmodule

// File: rtl/ecc_host_link.sv
// Host link to the ECC core: serialises PA/PB operand frames, deserialises Pa/Pab results.
module ecc_host_link import ECCDefine::*; #(
    parameter int unsigned MAX_BITS = ECCDefine::MAX_BITS
) (
    input logic            clk,
    input logic            rst,
    ecc_host_link_if.slave bus
);

    localparam int unsigned IdxW = $clog2(MAX_BITS);

    typedef enum logic [2:0] {
        StIdle, StPaHdr, StMode, StPaData, StPbHdr, StPbData
    } tx_state_e;

    tx_state_e           tx_state_q, tx_state_d;
    logic [1:0]          mode_q, mode_d;
    logic [MAX_REG-1:0]  cnt_q, cnt_d;
    logic [MAX_BITS-1:0] p_q, p_d, prime_q, prime_d, ax_q, ax_d, ay_q, ay_d;
    logic [MAX_BITS-1:0] pbx_q, pbx_d, pby_q, pby_d;
    logic [MAX_REG-1:0]  nbits;
    logic [IdxW-1:0]     idx;

    assign nbits = mode_nbits(mode_q);
    assign idx   = cnt_q[IdxW-1:0];

    always_comb begin
        tx_state_d = tx_state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        prime_d    = prime_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        pbx_d      = pbx_q;
        pby_d      = pby_q;
        case (tx_state_q)
            StIdle: begin
                // PA wins a simultaneous request; the PB request is simply lost.
                if (bus.i_start_pa) begin
                    tx_state_d = StPaHdr;
                    mode_d     = bus.i_mode;
                    p_d        = bus.i_P;
                    prime_d    = bus.i_prime;
                    ax_d       = bus.i_ax;
                    ay_d       = bus.i_ay;
                end else if (bus.i_start_pb) begin
                    tx_state_d = StPbHdr;
                    pbx_d      = bus.i_Pbx;
                    pby_d      = bus.i_Pby;
                end
            end
            StPaHdr: begin
                tx_state_d = StMode;
                cnt_d      = MAX_REG'(1);
            end
            StMode: begin
                if (cnt_q == '0) begin
                    tx_state_d = StPaData;
                    cnt_d      = nbits - MAX_REG'(1);
                end else begin
                    cnt_d = cnt_q - MAX_REG'(1);
                end
            end
            StPbHdr: begin
                tx_state_d = StPbData;
                cnt_d      = nbits - MAX_REG'(1);
            end
            StPaData, StPbData: begin
                if (cnt_q == '0) tx_state_d = StIdle;
                else             cnt_d      = cnt_q - MAX_REG'(1);
            end
            default: tx_state_d = StIdle;
        endcase
    end

    // Serial lines are pure decodes of state so they are quiet in every other cycle.
    always_comb begin
        bus.o_tx_ready  = (tx_state_q == StIdle);
        bus.o_p_a_valid = 1'b0;
        bus.o_mode      = 1'b0;
        bus.o_P         = 1'b0;
        bus.o_prime     = 1'b0;
        bus.o_ax        = 1'b0;
        bus.o_ay        = 1'b0;
        bus.o_pb_valid  = 1'b0;
        bus.o_Pbx       = 1'b0;
        bus.o_Pby       = 1'b0;
        case (tx_state_q)
            StPaHdr: bus.o_p_a_valid = 1'b1;
            StMode:  bus.o_mode      = mode_q[cnt_q[0]];
            StPaData: begin
                bus.o_P     = p_q[idx];
                bus.o_prime = prime_q[idx];
                bus.o_ax    = ax_q[idx];
                bus.o_ay    = ay_q[idx];
            end
            StPbHdr: bus.o_pb_valid = 1'b1;
            StPbData: begin
                bus.o_Pbx = pbx_q[idx];
                bus.o_Pby = pby_q[idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= StIdle;
            mode_q     <= BITS32;
            cnt_q      <= '0;
            p_q        <= '0;
            prime_q    <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            pbx_q      <= '0;
            pby_q      <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            prime_q    <= prime_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            pbx_q      <= pbx_d;
            pby_q      <= pby_d;
        end
    end

    ecc_deser #(.MAX_BITS(MAX_BITS)) u_rx_pa (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (bus.i_Pa_valid),
        .data_x_i   (bus.i_Pax),
        .data_y_i   (bus.i_Pay),
        .nbits_i    (nbits),
        .result_x_o (bus.o_pax),
        .result_y_o (bus.o_pay),
        .done_o     (bus.o_pa_done)
    );

    ecc_deser #(.MAX_BITS(MAX_BITS)) u_rx_pab (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (bus.i_Pab_valid),
        .data_x_i   (bus.i_Pabx),
        .data_y_i   (bus.i_Paby),
        .nbits_i    (nbits),
        .result_x_o (bus.o_pabx),
        .result_y_o (bus.o_paby),
        .done_o     (bus.o_pab_done)
    );

endmodule

// File: tb/tb_ecc_host_link.sv
// Directed, table-driven bench for ecc_host_link: TX framing, RX deserialisation, reset abort.
module tb_ecc_host_link;

    localparam int unsigned W = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ecc_host_link_if #(.MAX_BITS(W)) bus ();

    ecc_host_link #(.MAX_BITS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [1:0]   mode;
        int           n;
        logic [W-1:0] p, prime, ax, ay;
        logic [W-1:0] ep, eprime, eax, eay;
    } pa_vec_t;

    typedef struct {
        bit           chan;  // 0 = Pa, 1 = Pab
        int           n;
        int           drive;
        logic [W-1:0] vx, vy, ex, ey;
        bit           exp_done;
    } rx_vec_t;

    pa_vec_t pa_tab[4];
    rx_vec_t rx_tab[6];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [8:0] all_serial();
        return {bus.o_p_a_valid, bus.o_mode, bus.o_P, bus.o_prime, bus.o_ax, bus.o_ay,
                bus.o_pb_valid, bus.o_Pbx, bus.o_Pby};
    endfunction

    task automatic tx_pa(input int k, input bit with_pb);
        pa_vec_t      v;
        logic [W-1:0] gp, gq, gx, gy;
        int           bad;
        v   = pa_tab[k];
        bad = 0;
        gp  = '0; gq = '0; gx = '0; gy = '0;
        @(negedge clk);
        check("pa ready before", bus.o_tx_ready, 1'b1);
        bus.i_start_pa = 1'b1;
        bus.i_start_pb = with_pb;
        bus.i_mode  = v.mode;
        bus.i_P     = v.p;
        bus.i_prime = v.prime;
        bus.i_ax    = v.ax;
        bus.i_ay    = v.ay;
        bus.i_Pbx   = '1;
        bus.i_Pby   = '1;
        @(negedge clk);
        bus.i_start_pa = 1'b0;
        bus.i_start_pb = 1'b0;
        bus.i_P = ~v.p;
        bus.i_mode = ~v.mode;
        check("pa header", {bus.o_tx_ready, all_serial()}, 10'b0_1000_00000);
        @(negedge clk);
        check("pa mode msb", bus.o_mode, v.mode[1]);
        if ((all_serial() & 9'b1011_11111) != 0 || bus.o_tx_ready) bad++;
        @(negedge clk);
        check("pa mode lsb", bus.o_mode, v.mode[0]);
        if ((all_serial() & 9'b1011_11111) != 0 || bus.o_tx_ready) bad++;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            gp = {gp[W-2:0], bus.o_P};
            gq = {gq[W-2:0], bus.o_prime};
            gx = {gx[W-2:0], bus.o_ax};
            gy = {gy[W-2:0], bus.o_ay};
            if ((all_serial() & 9'b1100_00111) != 0 || bus.o_tx_ready) bad++;
        end
        @(negedge clk);
        check("pa ready after", bus.o_tx_ready, 1'b1);
        check("pa lines after", all_serial(), 9'b0);
        check("pa data P", gp, v.ep);
        check("pa data prime", gq, v.eprime);
        check("pa data ax", gx, v.eax);
        check("pa data ay", gy, v.eay);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (all_serial() != 0 || !bus.o_tx_ready) bad++;
        end
        check("pa stray activity", bad, 0);
    endtask

    task automatic tx_pb(input logic [W-1:0] x, input logic [W-1:0] y, input int n,
                         input logic [W-1:0] ex, input logic [W-1:0] ey);
        logic [W-1:0] gx, gy;
        int           bad;
        bad = 0;
        gx  = '0; gy = '0;
        @(negedge clk);
        check("pb ready before", bus.o_tx_ready, 1'b1);
        bus.i_start_pb = 1'b1;
        bus.i_Pbx = x;
        bus.i_Pby = y;
        @(negedge clk);
        bus.i_start_pb = 1'b0;
        bus.i_Pbx = ~x;
        bus.i_Pby = ~y;
        check("pb header", {bus.o_tx_ready, all_serial()}, 10'b0_0000_00100);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            gx = {gx[W-2:0], bus.o_Pbx};
            gy = {gy[W-2:0], bus.o_Pby};
            if ((all_serial() & 9'b1111_11100) != 0 || bus.o_tx_ready) bad++;
        end
        @(negedge clk);
        check("pb ready after", bus.o_tx_ready, 1'b1);
        check("pb lines after", all_serial(), 9'b0);
        check("pb data x", gx, ex);
        check("pb data y", gy, ey);
        check("pb stray activity", bad, 0);
    endtask

    task automatic rx_frame(input rx_vec_t r, input string tag);
        int   done_cnt, done_at;
        logic v, bx, by, d;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 0; c < r.drive + 4; c++) begin
            @(negedge clk);
            d = r.chan ? bus.o_pab_done : bus.o_pa_done;
            if (d) begin
                done_cnt++;
                done_at = c;
            end
            v  = (c < r.drive);
            bx = 1'b0;
            by = 1'b0;
            if (v && c < r.n) begin
                bx = r.vx[r.n-1-c];
                by = r.vy[r.n-1-c];
            end else if (v) begin
                bx = 1'b1;
                by = 1'b1;
            end
            if (r.chan) begin
                bus.i_Pab_valid = v; bus.i_Pabx = bx; bus.i_Paby = by;
            end else begin
                bus.i_Pa_valid = v; bus.i_Pax = bx; bus.i_Pay = by;
            end
        end
        check({tag, " done count"}, done_cnt, r.exp_done ? 1 : 0);
        if (r.exp_done) check({tag, " done cycle"}, done_at, r.n);
        check({tag, " result x"}, r.chan ? bus.o_pabx : bus.o_pax, r.ex);
        check({tag, " result y"}, r.chan ? bus.o_paby : bus.o_pay, r.ey);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int bad;

        pa_tab[0] = '{2'b00, 32, 256'h12345678_DEADBEEF, 256'hFFFFFFFF_FFFFFFFD,
                      256'h00000001_80000001, 256'h5,
                      256'hDEADBEEF, 256'hFFFFFFFD, 256'h80000001, 256'h5};
        pa_tab[1] = '{2'b10, 128,
            256'hCAFE0000_00000000_00000000_0000BABE_01234567_89ABCDEF_FEDCBA98_76543210,
            256'h80000000_00000000_00000000_00000001,
            256'h00000000_00000000_00000000_00000001_00000000_00000000_00000000_00000000,
            256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
            256'h01234567_89ABCDEF_FEDCBA98_76543210,
            256'h80000000_00000000_00000000_00000001,
            256'h0,
            256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF};
        pa_tab[2] = '{2'b01, 64, 256'h1_0F1E2D3C_4B5A6978, 256'hFFFFFFFF_FFFFFFC5,
                      256'h2, 256'hABCD_0000_0000_0000_1234,
                      256'h0F1E2D3C_4B5A6978, 256'hFFFFFFFF_FFFFFFC5, 256'h2, 256'h1234};
        pa_tab[3] = '{2'b11, 256,
            256'hFEDCBA98_76543210_01234567_89ABCDEF_00112233_44556677_8899AABB_CCDDEEFF,
            256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF,
            256'h6B17D1F2_E12C4247_F8BCE6E5_63A440F2_77037D81_2DEB33A0_F4A13945_D898C296,
            256'h4FE342E2_FE1A7F9B_8EE7EB4A_7C0F9E16_2BCE3357_6B315ECE_CBB64068_37BF51F5,
            256'hFEDCBA98_76543210_01234567_89ABCDEF_00112233_44556677_8899AABB_CCDDEEFF,
            256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF,
            256'h6B17D1F2_E12C4247_F8BCE6E5_63A440F2_77037D81_2DEB33A0_F4A13945_D898C296,
            256'h4FE342E2_FE1A7F9B_8EE7EB4A_7C0F9E16_2BCE3357_6B315ECE_CBB64068_37BF51F5};

        rx_tab[0] = '{1'b1, 32, 32, 256'hA5A5F00F, 256'h12345678,
                      256'hA5A5F00F, 256'h12345678, 1'b1};
        rx_tab[1] = '{1'b1, 32, 10, 256'hA5A5F00F, 256'h12345678, 256'h296, 256'h48, 1'b0};
        rx_tab[2] = '{1'b0, 32, 35, 256'h80000001, 256'hFFFFFFFF,
                      256'h80000001, 256'hFFFFFFFF, 1'b1};
        rx_tab[3] = '{1'b0, 64, 64, 256'h01234567_89ABCDEF, 256'hFEDCBA98_76543210,
                      256'h01234567_89ABCDEF, 256'hFEDCBA98_76543210, 1'b1};
        rx_tab[4] = '{1'b1, 64, 64, 256'hFFFFFFFF_00000000, 256'h1,
                      256'hFFFFFFFF_00000000, 256'h1, 1'b1};
        rx_tab[5] = '{1'b1, 64, 40, 256'hFFFFFFFF_00000000, 256'h1,
                      256'hFF_FFFFFF00, 256'h0, 1'b0};

        rst = 1'b1;
        bus.i_start_pa = 1'b0; bus.i_start_pb = 1'b0; bus.i_mode = 2'b00;
        bus.i_P = '0; bus.i_prime = '0; bus.i_ax = '0; bus.i_ay = '0;
        bus.i_Pbx = '0; bus.i_Pby = '0;
        bus.i_Pa_valid = 1'b0; bus.i_Pax = 1'b0; bus.i_Pay = 1'b0;
        bus.i_Pab_valid = 1'b0; bus.i_Pabx = 1'b0; bus.i_Paby = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx_ready", bus.o_tx_ready, 1'b1);
        check("reset serial", all_serial(), 9'b0);
        check("reset results", bus.o_pax | bus.o_pay | bus.o_pabx | bus.o_paby, '0);
        check("reset done", {bus.o_pa_done, bus.o_pab_done}, 2'b00);
        rst = 1'b0;

        // Pb before any PA frame: mode 00 from reset gives 32 bits.
        tx_pb(256'h1_23456789, 256'h0_80000000, 32, 256'h23456789, 256'h80000000);

        for (int i = 0; i < 6; i++)
            if (rx_tab[i].n == 32) rx_frame(rx_tab[i], $sformatf("rx%0d", i));

        for (int i = 0; i < 3; i++) tx_pa(i, 1'b0);

        for (int i = 0; i < 6; i++)
            if (rx_tab[i].n == 64) rx_frame(rx_tab[i], $sformatf("rx%0d", i));

        // Both RX channels overlapping a mode-01 PA transmission.
        fork
            tx_pa(2, 1'b0);
            rx_frame('{1'b0, 64, 64, 256'hDEADBEEF_CAFEF00D, 256'h1,
                       256'hDEADBEEF_CAFEF00D, 256'h1, 1'b1}, "ovl pa");
            rx_frame('{1'b1, 64, 64, 256'h5555AAAA_5555AAAA, 256'h80000000_00000000,
                       256'h5555AAAA_5555AAAA, 256'h80000000_00000000, 1'b1}, "ovl pab");
        join

        // Simultaneous start: PB must be dropped; then a 256-bit PB frame.
        tx_pa(3, 1'b1);
        tx_pb(pa_tab[3].ax, pa_tab[3].ay, 256, pa_tab[3].eax, pa_tab[3].eay);

        // Reset in the middle of a TX frame and a Pab RX frame.
        @(negedge clk);
        bus.i_start_pa = 1'b1;
        bus.i_mode = 2'b10;
        bus.i_P = '1;
        bus.i_Pab_valid = 1'b1; bus.i_Pabx = 1'b1; bus.i_Paby = 1'b1;
        repeat (12) begin
            @(negedge clk);
            bus.i_start_pa = 1'b0;
        end
        check("mid-frame busy", bus.o_tx_ready, 1'b0);
        rst = 1'b1;
        bus.i_Pab_valid = 1'b0; bus.i_Pabx = 1'b0; bus.i_Paby = 1'b0;
        @(negedge clk);
        check("rst tx_ready", bus.o_tx_ready, 1'b1);
        check("rst serial", all_serial(), 9'b0);
        check("rst results", bus.o_pax | bus.o_pay | bus.o_pabx | bus.o_paby, '0);
        check("rst done", {bus.o_pa_done, bus.o_pab_done}, 2'b00);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (all_serial() != 0 || !bus.o_tx_ready || bus.o_pa_done || bus.o_pab_done) bad++;
        end
        check("post-rst quiet", bad, 0);

        // Mode must be back to 00 after reset.
        tx_pb(256'hF0F0F0F0_0F0F0F0F, 256'h3, 32, 256'h0F0F0F0F, 256'h3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
